// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and checksum helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // P_RESET is the all-zero code; every other legal state is a single hot bit
  typedef enum logic [6:0] {
    P_RESET   = 7'h00,
    P_HUNT    = 7'h01,
    P_CMD     = 7'h02,
    P_LEN     = 7'h04,
    P_PAYLOAD = 7'h08,
    P_CHECK   = 7'h10,
    P_OUTPUT  = 7'h20,
    P_ERROR   = 7'h40
  } parser_state_t;

  typedef enum logic [3:0] {
    RX_IDLE  = 4'h0,
    RX_START = 4'h1,
    RX_DATA  = 4'h2,
    RX_STOP  = 4'h4,
    RX_ERROR = 4'h8
  } rx_state_t;

  typedef enum logic [3:0] {
    TX_IDLE  = 4'h0,
    TX_START = 4'h1,
    TX_DATA  = 4'h2,
    TX_STOP  = 4'h4,
    TX_ERROR = 4'h8
  } tx_state_t;

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Idle-cycle counter between accepted bytes; saturates at its limit and flags expiry.
`timescale 1ns/1ps
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 12_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count while enabled and not yet at the limit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Deframes SOF/CMD/LEN/payload/CHK byte streams into validated command frames.
`timescale 1ns/1ps
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MAX_PAYLOAD    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int                    TIMEOUT_CYCLES = 12_000,
  parameter int                    LEN_BITS       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             out_cmd,
  output logic [LEN_BITS-1:0]               out_len,
  output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] out_payload,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              err_checksum,
  output logic                              err_length,
  output logic                              err_timeout
);

  parser_state_t                     state_q;
  logic                              in_ready_q;
  logic                              out_valid_q;
  logic                              err_chk_q;
  logic                              err_len_q;
  logic                              err_to_q;
  logic [DATA_WIDTH-1:0]             cmd_q;
  logic [LEN_BITS-1:0]               len_q;
  logic [LEN_BITS-1:0]               idx_q;
  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_q;
  logic [7:0]                        sum_q;

  logic       accept_s;
  logic       in_frame_s;
  logic       expired_s;
  logic [7:0] sum_next_s;

  assign accept_s   = in_valid && in_ready_q;
  assign in_frame_s = (state_q == P_CMD) || (state_q == P_LEN) ||
                      (state_q == P_PAYLOAD) || (state_q == P_CHECK);
  assign sum_next_s = chk_add(sum_q, in_data[7:0]);

  // Frozen outside the in-frame states so a stalled consumer never times out
  uart_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept_s),
    .enable_i  (in_frame_s),
    .expired_o (expired_s)
  );

  // Parser FSM with registered handshake, frame and error outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= P_RESET;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      payload_q   <= '0;
      sum_q       <= 8'h00;
    end else begin
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      case (state_q)
        P_RESET: begin
          state_q    <= P_HUNT;
          in_ready_q <= 1'b1;
        end
        P_HUNT: begin
          if (accept_s && (in_data == SOF_BYTE)) begin
            state_q   <= P_CMD;
            payload_q <= '0;
            sum_q     <= 8'h00;
            idx_q     <= '0;
          end
        end
        P_CMD: begin
          if (accept_s) begin
            cmd_q   <= in_data;
            sum_q   <= sum_next_s;
            state_q <= P_LEN;
          end else if (expired_s) begin
            err_to_q <= 1'b1;
            state_q  <= P_HUNT;
          end
        end
        P_LEN: begin
          if (accept_s) begin
            len_q <= in_data[LEN_BITS-1:0];
            sum_q <= sum_next_s;
            if (in_data > DATA_WIDTH'(MAX_PAYLOAD)) begin
              err_len_q <= 1'b1;
              state_q   <= P_HUNT;
            end else if (in_data == '0) begin
              state_q <= P_CHECK;
            end else begin
              state_q <= P_PAYLOAD;
            end
          end else if (expired_s) begin
            err_to_q <= 1'b1;
            state_q  <= P_HUNT;
          end
        end
        P_PAYLOAD: begin
          if (accept_s) begin
            payload_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            sum_q <= sum_next_s;
            if (idx_q == (len_q - LEN_BITS'(1))) begin
              idx_q   <= '0;
              state_q <= P_CHECK;
            end else begin
              idx_q <= idx_q + LEN_BITS'(1);
            end
          end else if (expired_s) begin
            err_to_q <= 1'b1;
            state_q  <= P_HUNT;
          end
        end
        P_CHECK: begin
          if (accept_s) begin
            if (sum_next_s == 8'h00) begin
              state_q     <= P_OUTPUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              err_chk_q <= 1'b1;
              state_q   <= P_HUNT;
            end
          end else if (expired_s) begin
            err_to_q <= 1'b1;
            state_q  <= P_HUNT;
          end
        end
        P_OUTPUT: begin
          if (out_ready) begin
            state_q     <= P_HUNT;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        P_ERROR: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= P_ERROR;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_cmd      = cmd_q;
  assign out_len      = len_q;
  assign out_payload  = payload_q;
  assign err_checksum = err_chk_q;
  assign err_length   = err_len_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser.
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int DW = 8;
  localparam int MP = 16;
  localparam int TO = 40;
  localparam int LB = $clog2(MP + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     out_cmd;
  logic [LB-1:0]     out_len;
  logic [MP*DW-1:0]  out_payload;
  logic              out_valid;
  logic              out_ready;
  logic              err_checksum;
  logic              err_length;
  logic              err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_chk_p  = 0;
  int n_len_p  = 0;
  int n_to_p   = 0;
  int n_multi  = 0;
  int n_frames = 0;
  int n_ov_rise = 0;
  logic ov_prev = 1'b0;
  logic [7:0] seq [$];

  always #5 clk = ~clk;

  uart_frame_parser #(
    .DATA_WIDTH     (DW),
    .MAX_PAYLOAD    (MP),
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .LEN_BITS       (LB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_cmd      (out_cmd),
    .out_len      (out_len),
    .out_payload  (out_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_timeout  (err_timeout)
  );

  // Event counters sampled on the falling edge
  always @(negedge clk) begin
    if (err_checksum) n_chk_p++;
    if (err_length)   n_len_p++;
    if (err_timeout)  n_to_p++;
    if ((int'(err_checksum) + int'(err_length) + int'(err_timeout)) > 1) n_multi++;
    if (out_valid && out_ready) n_frames++;
    if (out_valid && !ov_prev) n_ov_rise++;
    ov_prev = out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_val("accept_bound", 128'(done), 128'd1);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("release_valid", 128'(out_valid), 128'd0);
    check_val("release_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_in_ready", 128'(in_ready), 128'd0);
    check_val("rst_out_valid", 128'(out_valid), 128'd0);
    check_val("rst_cmd", 128'(out_cmd), 128'd0);
    check_val("rst_len", 128'(out_len), 128'd0);
    check_val("rst_payload", out_payload, 128'd0);
    check_val("rst_errs", 128'({err_checksum, err_length, err_timeout}), 128'd0);
    rst_n = 1'b1;
    check_val("pre_hunt_ready", 128'(in_ready), 128'd0);
    tick();
    check_val("hunt_ready", 128'(in_ready), 128'd1);

    // Basic frame, output one cycle after CHK
    seq = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
    send_seq();
    check_val("f1_valid", 128'(out_valid), 128'd1);
    check_val("f1_ready", 128'(in_ready), 128'd0);
    check_val("f1_cmd", 128'(out_cmd), 128'h10);
    check_val("f1_len", 128'(out_len), 128'd2);
    check_val("f1_payload", out_payload, 128'h0201);
    release_frame();

    // Zero-length frame with a consumer stall longer than the timeout
    seq = '{8'hA5, 8'h20, 8'h00, 8'hE0};
    send_seq();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!(out_valid && !in_ready)) bad++;
    end
    check_val("stall_hold", 128'(bad), 128'd0);
    check_val("stall_no_to", 128'(n_to_p), 128'd0);
    check_val("f2_cmd", 128'(out_cmd), 128'h20);
    check_val("f2_len", 128'(out_len), 128'd0);
    release_frame();

    // Bad checksum, then a frame carrying the SOF value as data
    seq = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEC};
    send_seq();
    check_val("chk_pulse", 128'(err_checksum), 128'd1);
    check_val("chk_no_valid", 128'(out_valid), 128'd0);
    tick();
    check_val("chk_width", 128'(err_checksum), 128'd0);
    seq = '{8'hA5, 8'h33, 8'h01, 8'hA5, 8'h27};
    send_seq();
    check_val("f3_valid", 128'(out_valid), 128'd1);
    check_val("f3_cmd", 128'(out_cmd), 128'h33);
    check_val("f3_payload", out_payload, 128'hA5);
    release_frame();

    // Oversize length, trailing byte dropped silently, then maximum length
    seq = '{8'hA5, 8'h10, 8'h11};
    send_seq();
    check_val("len_pulse", 128'(err_length), 128'd1);
    seq = '{8'h33};
    send_seq();
    check_val("len_discard_errs", 128'({err_checksum, err_length, err_timeout}), 128'd0);
    check_val("len_discard_valid", 128'(out_valid), 128'd0);
    seq = '{8'hA5, 8'h01, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(8'(i));
    seq.push_back(8'h77);
    send_seq();
    check_val("max_valid", 128'(out_valid), 128'd1);
    check_val("max_len", 128'(out_len), 128'd16);
    check_val("max_payload", out_payload, 128'h0F0E0D0C0B0A09080706050403020100);
    release_frame();

    // Timeout after CMD
    seq = '{8'hA5, 8'h10};
    send_seq();
    repeat (TO - 1) tick();
    check_val("to_pre", 128'(err_timeout), 128'd0);
    tick();
    check_val("to_pulse", 128'(err_timeout), 128'd1);
    tick();
    check_val("to_width", 128'(err_timeout), 128'd0);

    // Byte on the limit cycle wins over the timeout; then time out in CHECK
    seq = '{8'hA5, 8'h10};
    send_seq();
    repeat (TO - 1) tick();
    send_byte(8'h00);
    check_val("to_honoured", 128'(err_timeout), 128'd0);
    repeat (TO - 1) tick();
    check_val("to2_pre", 128'(err_timeout), 128'd0);
    tick();
    check_val("to2_pulse", 128'(err_timeout), 128'd1);
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'hE0};
    send_seq();
    check_val("f5_valid", 128'(out_valid), 128'd1);
    check_val("f5_cmd", 128'(out_cmd), 128'h20);
    release_frame();

    // Reset mid-payload discards the partial frame
    seq = '{8'hA5, 8'h10, 8'h04, 8'h01, 8'h02};
    send_seq();
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_ready", 128'(in_ready), 128'd0);
    check_val("mid_rst_cmd", 128'(out_cmd), 128'd0);
    check_val("mid_rst_len", 128'(out_len), 128'd0);
    check_val("mid_rst_payload", out_payload, 128'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seq = '{8'hA5, 8'h44, 8'h02, 8'hAA, 8'hBB, 8'h55};
    send_seq();
    check_val("f6_valid", 128'(out_valid), 128'd1);
    check_val("f6_cmd", 128'(out_cmd), 128'h44);
    check_val("f6_len", 128'(out_len), 128'd2);
    check_val("f6_payload", out_payload, 128'hBBAA);
    release_frame();
    tick();

    check_val("cnt_frames", 128'(n_frames), 128'd6);
    check_val("cnt_valid_rises", 128'(n_ov_rise), 128'd6);
    check_val("cnt_chk", 128'(n_chk_p), 128'd1);
    check_val("cnt_len", 128'(n_len_p), 128'd1);
    check_val("cnt_to", 128'(n_to_p), 128'd2);
    check_val("cnt_multi", 128'(n_multi), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
